// File: rtl/burst_memory_if.sv
// Request/response channel of burst_memory. The master drives the request side,
// burst_memory (slave) drives req_ready and the read response.
interface burst_memory_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 14
);
  // Handshake: a request beat transfers on a rising clock edge where
  // req_valid & req_ready are both high. The master holds req_* stable while
  // req_valid is high and req_ready is low. rsp_valid has no backpressure.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic                  req_burst;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_last;

  modport master (
    output req_valid, req_we, req_burst, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_we, req_burst, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/burst_memory.sv
// Single-port data memory with byte strobes, wrapping cache-line bursts,
// an optional output register and a zero-clear engine run after reset.
module burst_memory #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 14,
  parameter int BURST_LEN      = 4,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clka,
  input  logic           rsta,
  burst_memory_if.slave  bus,
  output logic           busy,
  output logic [1:0]     state_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int SW    = DATA_W / 8;
  localparam int BW    = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN - 1);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RBURST, S_WBURST} state_t;

  state_t              state_q;
  logic                ready_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic [ADDR_W-1:0]   first_addr_q;
  logic [BW-1:0]       beat_q;

  logic                mem_we;
  logic                mem_re;
  logic                mem_last;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [SW-1:0]       mem_wstrb;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                rd_valid_q;
  logic                rd_last_q;
  logic [DATA_W-1:0]   rd_data_q;

  // Beat addresses stay inside the aligned line holding the first word.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [BW-1:0] beat);
    return (a & ~LINE_MASK) | ((a + ADDR_W'(beat)) & LINE_MASK);
  endfunction

  // Exactly one memory access is steered per cycle, chosen by the FSM state.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_last  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr_q;
        mem_wstrb = '1;
      end
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          mem_we    = bus.req_we;
          mem_re    = !bus.req_we;
          mem_last  = !bus.req_burst;
          mem_addr  = bus.req_addr;
          mem_wdata = bus.req_wdata;
          mem_wstrb = bus.req_wstrb;
        end
      end
      S_RBURST: begin
        mem_re   = 1'b1;
        mem_last = (beat_q == LAST_BEAT);
        mem_addr = line_addr(first_addr_q, beat_q);
      end
      S_WBURST: begin
        if (bus.req_valid) begin
          mem_we    = 1'b1;
          mem_addr  = line_addr(first_addr_q, beat_q);
          mem_wdata = bus.req_wdata;
          mem_wstrb = bus.req_wstrb;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      ready_q      <= (CLEAR_ON_RESET == 0);
      busy_q       <= (CLEAR_ON_RESET != 0);
      clr_addr_q   <= '0;
      first_addr_q <= '0;
      beat_q       <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == '1) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (bus.req_valid && ready_q && bus.req_burst) begin
            first_addr_q <= bus.req_addr;
            beat_q       <= BW'(1);
            if (bus.req_we) begin
              state_q <= S_WBURST;
            end else begin
              state_q <= S_RBURST;
              ready_q <= 1'b0;
            end
          end
        end
        S_RBURST: begin
          beat_q <= beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_WBURST: begin
          if (bus.req_valid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (mem_we) begin
      for (int b = 0; b < SW; b++) begin
        if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Read data only updates on a read, so rsp_data holds between responses.
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= mem_re;
      rd_last_q  <= mem_re & mem_last;
      if (mem_re) rd_data_q <= mem[mem_addr];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              out_valid_q;
      logic              out_last_q;
      logic [DATA_W-1:0] out_data_q;

      always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          out_data_q  <= '0;
        end else begin
          out_valid_q <= rd_valid_q;
          out_last_q  <= rd_last_q;
          if (rd_valid_q) out_data_q <= rd_data_q;
        end
      end

      assign bus.rsp_valid = out_valid_q;
      assign bus.rsp_last  = out_last_q;
      assign bus.rsp_data  = out_data_q;
    end else begin : g_no_out_reg
      assign bus.rsp_valid = rd_valid_q;
      assign bus.rsp_last  = rd_last_q;
      assign bus.rsp_data  = rd_data_q;
    end
  endgenerate

  assign bus.req_ready = ready_q;
  assign busy          = busy_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_burst_memory.sv
// Drives two burst_memory instances (OUT_REG=0 and OUT_REG=1) with identical
// requests and scores each response stream against a word-array model.
module tb_burst_memory;
  localparam int DW = 32, AW = 6, BL = 4, DEPTH = 64, SW = 4, EW = 65;

  logic clka = 1'b0;
  always #5 clka = ~clka;
  logic rsta;

  logic          req_valid, req_we, req_burst;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;

  burst_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  burst_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  logic       busy0, busy1;
  logic [1:0] st0, st1;

  assign bus0.req_valid = req_valid;  assign bus1.req_valid = req_valid;
  assign bus0.req_we    = req_we;     assign bus1.req_we    = req_we;
  assign bus0.req_burst = req_burst;  assign bus1.req_burst = req_burst;
  assign bus0.req_addr  = req_addr;   assign bus1.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;  assign bus1.req_wdata = req_wdata;
  assign bus0.req_wstrb = req_wstrb;  assign bus1.req_wstrb = req_wstrb;

  burst_memory #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .OUT_REG(0), .CLEAR_ON_RESET(1))
    dut0 (.clka(clka), .rsta(rsta), .bus(bus0), .busy(busy0), .state_o(st0));
  burst_memory #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .OUT_REG(1), .CLEAR_ON_RESET(1))
    dut1 (.clka(clka), .rsta(rsta), .bus(bus1), .busy(busy1), .state_o(st1));

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_mem [DEPTH];
  // Entry layout: {due cycle[64:33], last[32], data[31:0]}
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int i);
    int base;
    base = (int'(a) / BL) * BL;
    return AW'(base + ((int'(a) % BL) + i) % BL);
  endfunction

  task automatic mwrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int b = 0; b < SW; b++) if (s[b]) model_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input bit last, input int due);
    exp_q0.push_back({32'(due), last, d});
    exp_q1.push_back({32'(due + 1), last, d});
  endtask

  task automatic monitor_one(input string name, input logic [DW-1:0] d, input logic last);
    logic [EW-1:0] e;
    if (name == "dut0") begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected_rsp actual=%0h required=none", d);
        return;
      end
      e = exp_q0.pop_front();
    end else begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_rsp actual=%0h required=none", d);
        return;
      end
      e = exp_q1.pop_front();
    end
    chk({name, "_rsp_data"}, d, e[31:0]);
    chk({name, "_rsp_last"}, last, e[32]);
    chk({name, "_rsp_cycle"}, cyc, e[64:33]);
  endtask

  always @(negedge clka) begin
    if (rsta === 1'b1) begin
      if (bus0.rsp_valid) monitor_one("dut0", bus0.rsp_data, bus0.rsp_last);
      if (bus1.rsp_valid) monitor_one("dut1", bus1.rsp_data, bus1.rsp_last);
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!bus0.req_ready && n < 100) begin
      @(negedge clka);
      n++;
    end
    ok = bus0.req_ready;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic issue(input bit we, input bit burst, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s, output bit ok);
    req_valid = 1'b1; req_we = we; req_burst = burst;
    req_addr = a; req_wdata = d; req_wstrb = s;
    wait_ready(ok);
  endtask

  task automatic single_read(input logic [AW-1:0] a);
    bit ok;
    issue(1'b0, 1'b0, a, DW'($urandom), SW'($urandom), ok);
    push_exp(model_mem[a], 1'b1, cyc + 1);
    @(negedge clka);
    req_valid = 1'b0;
  endtask

  task automatic single_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    bit ok;
    issue(1'b1, 1'b0, a, d, s, ok);
    mwrite(a, d, s);
    @(negedge clka);
    req_valid = 1'b0;
  endtask

  task automatic burst_read(input logic [AW-1:0] a);
    bit ok;
    int k;
    issue(1'b0, 1'b1, a, DW'($urandom), SW'($urandom), ok);
    k = cyc + 1;
    for (int i = 0; i < BL; i++) push_exp(model_mem[beat_addr(a, i)], i == BL - 1, k + i);
    @(negedge clka);
    req_valid = 1'b0;
    for (int j = 0; j < BL - 1; j++) begin
      chk("rburst_ready_low0", bus0.req_ready, 0);
      chk("rburst_ready_low1", bus1.req_ready, 0);
      @(negedge clka);
    end
    chk("rburst_ready_back", bus0.req_ready, 1);
  endtask

  task automatic burst_write(input logic [AW-1:0] a, input logic [BL*DW-1:0] dpk,
                             input logic [BL*SW-1:0] spk, input logic [BL-1:0] gap, input int max_gap);
    bit ok;
    issue(1'b1, 1'b1, a, dpk[0 +: DW], spk[0 +: SW], ok);
    mwrite(a, dpk[0 +: DW], spk[0 +: SW]);
    @(negedge clka);
    for (int i = 1; i < BL; i++) begin
      if (gap[i]) begin
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        repeat ($urandom_range(1, max_gap)) @(negedge clka);
      end
      req_valid = 1'b1;
      req_we    = 1'($urandom);
      req_burst = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = dpk[i*DW +: DW];
      req_wstrb = spk[i*SW +: SW];
      wait_ready(ok);
      mwrite(beat_addr(a, i), dpk[i*DW +: DW], spk[i*SW +: SW]);
      @(negedge clka);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 50) begin
      @(negedge clka);
      n++;
    end
    chk("drain_pending", exp_q0.size() + exp_q1.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready0"}, bus0.req_ready, 0);  chk({tag, "_ready1"}, bus1.req_ready, 0);
    chk({tag, "_valid0"}, bus0.rsp_valid, 0);  chk({tag, "_valid1"}, bus1.rsp_valid, 0);
    chk({tag, "_data0"}, bus0.rsp_data, 0);    chk({tag, "_data1"}, bus1.rsp_data, 0);
    chk({tag, "_last0"}, bus0.rsp_last, 0);    chk({tag, "_last1"}, bus1.rsp_last, 0);
    chk({tag, "_busy0"}, busy0, 1);            chk({tag, "_busy1"}, busy1, 1);
  endtask

  // Called at the negedge where rsta is released.
  task automatic clear_check(input string tag);
    int n = 0, bad = 0;
    while (busy0 && n < 200) begin
      if (bus0.req_ready || bus1.req_ready || !busy1) bad++;
      @(negedge clka);
      n++;
    end
    chk({tag, "_clear_cycles"}, n, DEPTH);
    chk({tag, "_clear_violations"}, bad, 0);
    chk({tag, "_busy1_done"}, busy1, 0);
    chk({tag, "_ready0_after"}, bus0.req_ready, 1);
    chk({tag, "_ready1_after"}, bus1.req_ready, 1);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BL*DW-1:0] dpk;
    logic [BL*SW-1:0] spk;
    bit ok;
    int k;
    rsta = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_burst = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge clka);
    check_reset("por");
    rsta = 1'b1;
    clear_check("por");
    for (int a = 0; a < DEPTH; a++) single_read(AW'(a));
    drain();

    single_write(6'd5, 32'hDEADBEEF, 4'b1111);
    single_read(6'd5);
    single_write(6'd5, 32'h00001234, 4'b0011);
    single_read(6'd5);
    drain();

    burst_write(6'h0E, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, '1, 4'b0100, 1);
    burst_read(6'h0F);
    burst_write(6'h3E, {32'h14, 32'h13, 32'h12, 32'h11}, '1, 4'b0000, 1);
    burst_read(6'h3C);
    single_read(6'h00);
    drain();

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: single_write(AW'($urandom), DW'($urandom), SW'($urandom));
        1: single_read(AW'($urandom));
        2: begin
          for (int i = 0; i < BL; i++) begin
            dpk[i*DW +: DW] = DW'($urandom);
            spk[i*SW +: SW] = SW'($urandom);
          end
          burst_write(AW'($urandom), dpk, spk, BL'($urandom), 2);
        end
        default: burst_read(AW'($urandom));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clka);
    end
    drain();

    // Reset in the middle of a burst read.
    issue(1'b0, 1'b1, 6'h0E, '0, '0, ok);
    k = cyc + 1;
    for (int i = 0; i < BL; i++) push_exp(model_mem[beat_addr(6'h0E, i)], i == BL - 1, k + i);
    @(negedge clka);
    req_valid = 1'b0;
    @(negedge clka);
    chk("pre_reset_valid0", bus0.rsp_valid, 1);
    #2 rsta = 1'b0;
    #1;
    check_reset("mid");
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(negedge clka);
    rsta = 1'b1;
    clear_check("mid");
    for (int a = 0; a < DEPTH; a++) single_read(AW'(a));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
